// File: rtl/apb_reg_subordinate.sv
// APB completer with a bank of byte-strobed software registers, programmable
// wait states and an error response for misaligned, out-of-range or unprivileged accesses.
module apb_reg_subordinate #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int RegNum        = 8,
  parameter int WaitCycles    = 0,
  parameter int ProtectWrites = 0
) (
  input  logic                          clk,
  input  logic                          nReset,
  input  logic [AddrWidth-1:0]          addr,
  input  logic                          sel,
  input  logic                          enable,
  input  logic                          write,
  input  logic [DataWidth-1:0]          wData,
  input  logic [DataWidth/8-1:0]        strb,
  input  logic [3:0]                    prot,
  output logic                          ready,
  output logic [DataWidth-1:0]          rData,
  output logic                          subError,
  output logic [RegNum*DataWidth-1:0]   regs
);

  localparam int ByteLanes = DataWidth / 8;
  localparam int LaneShift = $clog2(ByteLanes);
  localparam int IdxW      = $clog2(RegNum);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state_reg;
  logic [3:0]             cnt_reg;
  logic [AddrWidth-1:0]   addr_reg;
  logic                   write_reg;
  logic [DataWidth-1:0]   wdata_reg;
  logic [ByteLanes-1:0]   strb_reg;
  logic                   priv_reg;

  logic [DataWidth-1:0]   reg_file [RegNum];

  logic [AddrWidth-1:0]   word_addr;
  logic [IdxW-1:0]        idx;
  logic                   misaligned;
  logic                   out_of_range;
  logic                   denied;
  logic                   bad;

  // Only the privilege bit of prot matters here.
  logic unused_prot;
  assign unused_prot = ^prot[3:1];

  // Decode works purely on the latched setup-phase copies.
  assign word_addr    = addr_reg >> LaneShift;
  assign idx          = word_addr[IdxW-1:0];
  assign misaligned   = |(addr_reg & AddrWidth'(ByteLanes - 1));
  assign out_of_range = word_addr >= AddrWidth'(RegNum);
  assign denied       = write_reg & (ProtectWrites != 0) & ~priv_reg;
  assign bad          = misaligned | out_of_range | denied;

  assign ready    = (state_reg == ACCESS) & (cnt_reg == 4'd0) & sel & enable;
  assign subError = ready & bad;
  assign rData    = (ready & ~write_reg & ~bad) ? reg_file[idx] : '0;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      priv_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // sel with enable already high is a protocol violation and is ignored.
          if (sel && !enable) begin
            addr_reg  <= addr;
            write_reg <= write;
            wdata_reg <= wData;
            strb_reg  <= strb;
            priv_reg  <= prot[0];
            cnt_reg   <= 4'(WaitCycles);
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (sel && enable) begin
            if (cnt_reg != 4'd0) begin
              cnt_reg <= cnt_reg - 4'd1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg   <= 4'd0;
            state_reg <= IDLE;
          end
        end
        default: begin
          cnt_reg   <= 4'd0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RegNum; gi++) begin : g_reg
      logic wr_en;
      assign wr_en = ready & write_reg & ~bad & (idx == IdxW'(gi));

      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          reg_file[gi] <= '0;
        end else if (wr_en) begin
          for (int b = 0; b < ByteLanes; b++) begin
            if (strb_reg[b]) begin
              reg_file[gi][8*b +: 8] <= wdata_reg[8*b +: 8];
            end
          end
        end
      end

      assign regs[gi*DataWidth +: DataWidth] = reg_file[gi];
    end
  endgenerate

endmodule

// File: tb/tb_apb_reg_subordinate.sv
// Directed bench for apb_reg_subordinate: three instances on separate select lanes
// (no waits, three waits, write protection) driven from one shared APB bus.
module tb_apb_reg_subordinate;

  logic         clk = 1'b0;
  logic         nReset;
  logic [31:0]  addr;
  logic [2:0]   sel;
  logic         enable;
  logic         write;
  logic [31:0]  wData;
  logic [3:0]   strb;
  logic [3:0]   prot;
  logic [2:0]   ready;
  logic [2:0]   subError;
  logic [31:0]  rData [3];
  logic [255:0] regs [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_reg_subordinate #(.WaitCycles(0), .ProtectWrites(0)) u_w0 (
    .clk(clk), .nReset(nReset), .addr(addr), .sel(sel[0]), .enable(enable),
    .write(write), .wData(wData), .strb(strb), .prot(prot),
    .ready(ready[0]), .rData(rData[0]), .subError(subError[0]), .regs(regs[0]));

  apb_reg_subordinate #(.WaitCycles(3), .ProtectWrites(0)) u_w3 (
    .clk(clk), .nReset(nReset), .addr(addr), .sel(sel[1]), .enable(enable),
    .write(write), .wData(wData), .strb(strb), .prot(prot),
    .ready(ready[1]), .rData(rData[1]), .subError(subError[1]), .regs(regs[1]));

  apb_reg_subordinate #(.WaitCycles(0), .ProtectWrites(1)) u_prot (
    .clk(clk), .nReset(nReset), .addr(addr), .sel(sel[2]), .enable(enable),
    .write(write), .wData(wData), .strb(strb), .prot(prot),
    .ready(ready[2]), .rData(rData[2]), .subError(subError[2]), .regs(regs[2]));

  // Called just after a rising edge; returns just after the completion edge.
  task automatic xfer(input int lane, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s, input logic [3:0] p,
                      input bit keep, input bit wiggle,
                      output logic [31:0] rd, output logic err, output int waits);
    bit done;
    done = 0; waits = 0; rd = '0; err = 1'b0;
    sel = 3'b001 << lane; enable = 1'b0;
    addr = a; write = w; wData = d; strb = s; prot = p;
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (ready[lane]) begin
        rd = rData[lane]; err = subError[lane]; done = 1;
      end else begin
        vectors++;
        if (rData[lane] !== 32'h0 || subError[lane] !== 1'b0) begin
          miscompares++;
          $display("FAIL wait_outputs lane%0d: rData=%h subError=%b, required 00000000/0",
                   lane, rData[lane], subError[lane]);
        end
      end
      @(posedge clk); #1;
      if (done) break;
      waits++;
      if (wiggle) begin
        addr = a ^ 32'h0000_0023; wData = ~d; strb = ~s;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout lane%0d addr=%h: ready never rose, required within 32 cycles", lane, a);
    end
    if (!keep) begin
      sel = '0; enable = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    sel = '0; enable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    nReset = 1'b0; sel = '0; enable = 1'b0; addr = '0; write = 1'b0;
    wData = '0; strb = '0; prot = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      vectors++;
      if (ready[l] !== 1'b0 || subError[l] !== 1'b0 || rData[l] !== 32'h0 || regs[l] !== 256'h0) begin
        miscompares++;
        $display("FAIL reset_state lane%0d: ready=%b subError=%b rData=%h regs=%h, required all zero",
                 l, ready[l], subError[l], rData[l], regs[l]);
      end
    end
    @(posedge clk); #1;
    nReset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_all();
    logic [31:0] rd; logic err; int waits;
    for (int i = 0; i < 8; i++) begin
      xfer(0, 32'(i * 4), 1'b0, 32'h0, 4'hF, 4'h0, 0, 0, rd, err, waits);
      vectors++;
      if (waits !== 0 || rd !== 32'h0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL read_after_reset idx%0d: waits=%0d rData=%h err=%b, required 0/00000000/0",
                 i, waits, rd, err);
      end
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err; int waits;
    xfer(0, 32'h08, 1'b1, 32'hDEADBEEF, 4'hF, 4'h0, 0, 0, rd, err, waits);
    vectors++;
    if (err !== 1'b0 || regs[0][95:64] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_full: err=%b reg2=%h, required 0/deadbeef", err, regs[0][95:64]);
    end
    xfer(0, 32'h08, 1'b1, 32'h11223344, 4'h5, 4'h0, 0, 0, rd, err, waits);
    vectors++;
    if (err !== 1'b0 || regs[0][95:64] !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL write_strb5: err=%b reg2=%h, required 0/de22be44", err, regs[0][95:64]);
    end
    xfer(0, 32'h08, 1'b1, 32'hFFFFFFFF, 4'h0, 4'h0, 0, 0, rd, err, waits);
    vectors++;
    if (err !== 1'b0 || regs[0][95:64] !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL write_strb0: err=%b reg2=%h, required 0/de22be44", err, regs[0][95:64]);
    end
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 4'h0, 0, 0, rd, err, waits);
    vectors++;
    if (err !== 1'b0 || rd !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL readback_reg2: err=%b rData=%h, required 0/de22be44", err, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int waits;
    xfer(0, 32'h0C, 1'b1, 32'hA5A55A5A, 4'hF, 4'h0, 1, 0, rd, err, waits);
    xfer(0, 32'h0C, 1'b0, 32'h0, 4'hF, 4'h0, 1, 0, rd, err, waits);
    vectors++;
    if (waits !== 0 || err !== 1'b0 || rd !== 32'hA5A55A5A) begin
      miscompares++;
      $display("FAIL b2b_reg3: waits=%0d err=%b rData=%h, required 0/0/a5a55a5a", waits, err, rd);
    end
    xfer(0, 32'h1C, 1'b1, 32'h12345678, 4'hF, 4'h0, 1, 0, rd, err, waits);
    xfer(0, 32'h1C, 1'b0, 32'h0, 4'hF, 4'h0, 0, 0, rd, err, waits);
    vectors++;
    if (waits !== 0 || err !== 1'b0 || rd !== 32'h12345678) begin
      miscompares++;
      $display("FAIL b2b_reg7: waits=%0d err=%b rData=%h, required 0/0/12345678", waits, err, rd);
    end
  endtask

  task automatic test_protocol_violation();
    sel = 3'b001; enable = 1'b1; addr = 32'h0; write = 1'b1;
    wData = 32'hFFFFFFFF; strb = 4'hF; prot = 4'h0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (ready[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL violation_ready: ready=%b, required 0", ready[0]);
      end
      @(posedge clk); #1;
    end
    idle(1);
    vectors++;
    if (regs[0][31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL violation_nowrite: reg0=%h, required 00000000", regs[0][31:0]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int waits;
    logic [255:0] exp_regs;
    logic [31:0] err_addr [4];
    logic        err_wr   [4];
    exp_regs = {32'h12345678, 96'h0, 32'hA5A55A5A, 32'hDE22BE44, 64'h0};
    err_addr = '{32'h20, 32'h06, 32'h02, 32'h20};
    err_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      xfer(0, err_addr[i], err_wr[i], 32'hFFFFFFFF, 4'hF, 4'h0, 0, 0, rd, err, waits);
      vectors++;
      if (err !== 1'b1 || rd !== 32'h0) begin
        miscompares++;
        $display("FAIL error_resp addr=%h write=%b: err=%b rData=%h, required 1/00000000",
                 err_addr[i], err_wr[i], err, rd);
      end
    end
    vectors++;
    if (regs[0] !== exp_regs) begin
      miscompares++;
      $display("FAIL error_nowrite: regs=%h, required %h", regs[0], exp_regs);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int waits;
    xfer(1, 32'h04, 1'b1, 32'hCAFEF00D, 4'hF, 4'h0, 0, 0, rd, err, waits);
    vectors++;
    if (waits !== 3 || err !== 1'b0 || regs[1][63:32] !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL wait_write: waits=%0d err=%b reg1=%h, required 3/0/cafef00d", waits, err, regs[1][63:32]);
    end
    xfer(1, 32'h04, 1'b0, 32'h0, 4'hF, 4'h0, 0, 1, rd, err, waits);
    vectors++;
    if (waits !== 3 || err !== 1'b0 || rd !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL wait_read_wiggle: waits=%0d err=%b rData=%h, required 3/0/cafef00d", waits, err, rd);
    end
    xfer(1, 32'h08, 1'b1, 32'h0BADCAFE, 4'hF, 4'h0, 0, 1, rd, err, waits);
    vectors++;
    if (waits !== 3 || err !== 1'b0 || regs[1][95:64] !== 32'h0BADCAFE) begin
      miscompares++;
      $display("FAIL wait_write_wiggle: waits=%0d err=%b reg2=%h, required 3/0/0badcafe", waits, err, regs[1][95:64]);
    end
  endtask

  task automatic test_protect();
    logic [31:0] rd; logic err; int waits;
    xfer(2, 32'h0, 1'b1, 32'h55AA55AA, 4'hF, 4'b0000, 0, 0, rd, err, waits);
    vectors++;
    if (err !== 1'b1 || regs[2][31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL protect_unpriv: err=%b reg0=%h, required 1/00000000", err, regs[2][31:0]);
    end
    xfer(2, 32'h0, 1'b1, 32'h55AA55AA, 4'hF, 4'b0001, 0, 0, rd, err, waits);
    vectors++;
    if (err !== 1'b0 || regs[2][31:0] !== 32'h55AA55AA) begin
      miscompares++;
      $display("FAIL protect_priv: err=%b reg0=%h, required 0/55aa55aa", err, regs[2][31:0]);
    end
    xfer(2, 32'h0, 1'b0, 32'h0, 4'hF, 4'b0000, 0, 0, rd, err, waits);
    vectors++;
    if (err !== 1'b0 || rd !== 32'h55AA55AA) begin
      miscompares++;
      $display("FAIL protect_read: err=%b rData=%h, required 0/55aa55aa", err, rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int waits;
    // Reset asserted during a wait state of a write to reg3.
    sel = 3'b010; enable = 1'b0; addr = 32'h0C; write = 1'b1;
    wData = 32'h77777777; strb = 4'hF; prot = 4'h0;
    @(posedge clk); #1; enable = 1'b1;
    @(posedge clk); #1; nReset = 1'b0;
    #1;
    vectors++;
    if (regs[1] !== 256'h0 || ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: regs=%h ready=%b, required 0/0", regs[1], ready[1]);
    end
    @(posedge clk); #1;
    sel = '0; enable = 1'b0; nReset = 1'b1;
    idle(2);
    xfer(1, 32'h0C, 1'b0, 32'h0, 4'hF, 4'h0, 0, 0, rd, err, waits);
    vectors++;
    if (waits !== 3 || err !== 1'b0 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL after_reset_read: waits=%0d err=%b rData=%h, required 3/0/00000000", waits, err, rd);
    end
    // Abort by dropping sel during the waits.
    sel = 3'b010; enable = 1'b0; addr = 32'h0C; write = 1'b1;
    wData = 32'h99999999; strb = 4'hF; prot = 4'h0;
    @(posedge clk); #1; enable = 1'b1;
    @(posedge clk); #1; sel = '0;
    @(negedge clk);
    vectors++;
    if (ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ready: ready=%b, required 0", ready[1]);
    end
    @(posedge clk); #1;
    idle(2);
    vectors++;
    if (regs[1][127:96] !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_nowrite: reg3=%h, required 00000000", regs[1][127:96]);
    end
    xfer(1, 32'h0C, 1'b1, 32'h13579BDF, 4'hF, 4'h0, 0, 0, rd, err, waits);
    vectors++;
    if (waits !== 3 || err !== 1'b0 || regs[1][127:96] !== 32'h13579BDF) begin
      miscompares++;
      $display("FAIL after_abort_write: waits=%0d err=%b reg3=%h, required 3/0/13579bdf",
               waits, err, regs[1][127:96]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_all();
    test_strobes();
    test_back_to_back();
    test_protocol_violation();
    test_errors();
    test_wait_states();
    test_protect();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
